viterbi_seq_ctrl: RTL and testbench

Sequencer for the Viterbi tagger datapath. It walks the word/POS trellis column by column and drives the 11-way max/argmax comparator tree with its enable and last-column latch strobe. It writes each argmax result into the backpointer memory, then runs the traceback that emits the final tag path. It sits between the sentence-level host handshake (start/done) and the probability memories, comparator tree and backpointer RAM.

---
 rtl/viterbi_pkg.sv | 22 ++
 rtl/viterbi_seq_ctrl_trellis_counter.sv | 44 ++++
 rtl/viterbi_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_viterbi_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and state encoding for the Viterbi tagger sequencer.
package viterbi_pkg;

    localparam int WORD_NUM     = 16;
    localparam int WORD_NUM_BIT = 4;
    localparam int POS_NUM      = 11;
    localparam int POS_NUM_BIT  = 4;

    localparam logic [POS_NUM_BIT-1:0] LAST_POS = 4'(POS_NUM - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        FWD     = 3'd2,
        FINAL   = 3'd3,
        TB_SEED = 3'd4,
        TB_RD   = 3'd5,
        TB_WR   = 3'd6,
        DONE    = 3'd7
    } viterbi_ctrl_state_t;

endpackage

// File: rtl/viterbi_seq_ctrl_trellis_counter.sv
// Nested word/pos counter used to sweep the trellis during INIT and FWD.
module trellis_counter #(
    parameter int WORD_NUM_BIT = 4,
    parameter int POS_NUM_BIT  = 4,
    parameter logic [POS_NUM_BIT-1:0] POS_LAST = 4'd10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic [WORD_NUM_BIT-1:0] word_last,
    output logic [WORD_NUM_BIT-1:0] word,
    output logic [POS_NUM_BIT-1:0]  pos,
    output logic                    pos_wrap,
    output logic                    term
);

    logic [WORD_NUM_BIT-1:0] word_r;
    logic [POS_NUM_BIT-1:0]  pos_r;

    // pos runs 0..POS_LAST, then wraps and carries into word
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_r <= {WORD_NUM_BIT{1'b0}};
            pos_r  <= {POS_NUM_BIT{1'b0}};
        end else if (clear) begin
            word_r <= {WORD_NUM_BIT{1'b0}};
            pos_r  <= {POS_NUM_BIT{1'b0}};
        end else if (en) begin
            if (pos_r == POS_LAST) begin
                pos_r  <= {POS_NUM_BIT{1'b0}};
                word_r <= word_r + WORD_NUM_BIT'(1);
            end else begin
                pos_r  <= pos_r + POS_NUM_BIT'(1);
            end
        end
    end

    assign word     = word_r;
    assign pos      = pos_r;
    assign pos_wrap = (pos_r == POS_LAST);
    assign term     = (pos_r == POS_LAST) && (word_r == word_last);

endmodule

// File: rtl/viterbi_seq_ctrl.sv
// Trellis sequencer: forward pass over word/POS columns, then backpointer traceback.
module viterbi_seq_ctrl #(
    parameter int WORD_NUM     = viterbi_pkg::WORD_NUM,
    parameter int WORD_NUM_BIT = viterbi_pkg::WORD_NUM_BIT,
    parameter int POS_NUM      = viterbi_pkg::POS_NUM,
    parameter int POS_NUM_BIT  = viterbi_pkg::POS_NUM_BIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WORD_NUM_BIT:0]   num_words,
    input  logic                    abort,
    input  logic [POS_NUM_BIT-1:0]  max_index,
    input  logic [POS_NUM_BIT-1:0]  last_pos,
    input  logic [POS_NUM_BIT-1:0]  bp_rdata,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_NUM_BIT-1:0] word_idx,
    output logic [POS_NUM_BIT-1:0]  pos_idx,
    output logic                    init_we,
    output logic                    max_en,
    output logic                    prob_we,
    output logic                    bp_we,
    output logic                    rw_last,
    output logic                    bp_re,
    output logic                    path_we,
    output logic [WORD_NUM_BIT-1:0] path_addr,
    output logic [POS_NUM_BIT-1:0]  path_tag
);

    import viterbi_pkg::*;

    localparam logic [POS_NUM_BIT-1:0]  POS_LAST  = POS_NUM_BIT'(POS_NUM - 1);
    localparam logic [WORD_NUM_BIT:0]   LEN_MAX   = (WORD_NUM_BIT+1)'(WORD_NUM);
    localparam logic [WORD_NUM_BIT:0]   LEN_ZERO  = (WORD_NUM_BIT+1)'(0);
    localparam logic [WORD_NUM_BIT:0]   LEN_ONE   = (WORD_NUM_BIT+1)'(1);
    localparam logic [WORD_NUM_BIT-1:0] WORD_ONE  = WORD_NUM_BIT'(1);
    localparam logic [WORD_NUM_BIT-1:0] WORD_ZERO = WORD_NUM_BIT'(0);
    localparam logic [POS_NUM_BIT-1:0]  POS_ZERO  = POS_NUM_BIT'(0);

    viterbi_ctrl_state_t     state_r, state_s;
    logic [WORD_NUM_BIT:0]   n_r;
    logic [WORD_NUM_BIT-1:0] w_r;
    logic [POS_NUM_BIT-1:0]  cur_tag_r;
    logic [WORD_NUM_BIT-1:0] last_word_s;
    logic                    accept_s;
    logic                    cnt_clear_s, cnt_en_s, cnt_pos_wrap_s, cnt_term_s;
    logic [WORD_NUM_BIT-1:0] cnt_word_s;
    logic [POS_NUM_BIT-1:0]  cnt_pos_s;

    assign accept_s    = (state_r == IDLE) && start && (num_words != LEN_ZERO) && !abort;
    assign last_word_s = WORD_NUM_BIT'(n_r - LEN_ONE);
    assign cnt_clear_s = (state_r == IDLE);
    assign cnt_en_s    = (state_r == INIT) || (state_r == FWD);

    trellis_counter #(
        .WORD_NUM_BIT(WORD_NUM_BIT),
        .POS_NUM_BIT (POS_NUM_BIT),
        .POS_LAST    (POS_LAST)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear_s),
        .en       (cnt_en_s),
        .word_last(last_word_s),
        .word     (cnt_word_s),
        .pos      (cnt_pos_s),
        .pos_wrap (cnt_pos_wrap_s),
        .term     (cnt_term_s)
    );

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? INIT : IDLE;
            INIT:    state_s = cnt_pos_wrap_s ? ((n_r > LEN_ONE) ? FWD : FINAL) : INIT;
            FWD:     state_s = cnt_term_s ? FINAL : FWD;
            FINAL:   state_s = TB_SEED;
            TB_SEED: state_s = (n_r == LEN_ONE) ? DONE : TB_RD;
            TB_RD:   state_s = TB_WR;
            TB_WR:   state_s = (w_r == WORD_ONE) ? DONE : TB_RD;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        if (abort) begin
            state_s = IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // State, sentence length and traceback cursor registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            n_r       <= LEN_ZERO;
            w_r       <= WORD_ZERO;
            cur_tag_r <= POS_ZERO;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                n_r <= (num_words > LEN_MAX) ? LEN_MAX : num_words;
            end
            case (state_r)
                TB_SEED: begin
                    cur_tag_r <= last_pos;
                    w_r       <= last_word_s;
                end
                TB_WR: begin
                    cur_tag_r <= bp_rdata;
                    w_r       <= w_r - WORD_ONE;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode the current state; path_tag forwards bp_rdata in TB_WR
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        word_idx  = WORD_ZERO;
        pos_idx   = POS_ZERO;
        init_we   = 1'b0;
        max_en    = 1'b0;
        prob_we   = 1'b0;
        bp_we     = 1'b0;
        rw_last   = 1'b0;
        bp_re     = 1'b0;
        path_we   = 1'b0;
        path_addr = WORD_ZERO;
        path_tag  = POS_ZERO;
        case (state_r)
            INIT: begin
                busy     = 1'b1;
                word_idx = cnt_word_s;
                pos_idx  = cnt_pos_s;
                init_we  = 1'b1;
            end
            FWD: begin
                busy     = 1'b1;
                word_idx = cnt_word_s;
                pos_idx  = cnt_pos_s;
                max_en   = 1'b1;
                prob_we  = 1'b1;
                bp_we    = 1'b1;
            end
            FINAL: begin
                busy     = 1'b1;
                word_idx = last_word_s;
                max_en   = 1'b1;
                rw_last  = 1'b1;
            end
            TB_SEED: begin
                busy      = 1'b1;
                path_we   = 1'b1;
                path_addr = last_word_s;
                path_tag  = last_pos;
            end
            TB_RD: begin
                busy     = 1'b1;
                bp_re    = 1'b1;
                word_idx = w_r;
                pos_idx  = cur_tag_r;
            end
            TB_WR: begin
                busy      = 1'b1;
                path_we   = 1'b1;
                path_addr = w_r - WORD_ONE;
                path_tag  = bp_rdata;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_viterbi_seq_ctrl.sv
// Directed bench for viterbi_seq_ctrl with models of the comparator tree and backpointer RAM.
module tb_viterbi_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] num_words = 5'd0;
    logic       abort = 1'b0;
    logic [3:0] max_index;
    logic [3:0] last_pos = 4'd0;
    logic [3:0] bp_rdata = 4'd0;
    logic       busy, done, init_we, max_en, prob_we, bp_we, rw_last, bp_re, path_we;
    logic [3:0] word_idx, pos_idx, path_addr, path_tag;
    logic       max_mode = 1'b0;
    logic [3:0] bp_mem [0:15][0:15];
    logic [24:0] all_out;

    int passed = 0;
    int total  = 0;

    viterbi_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words), .abort(abort),
        .max_index(max_index), .last_pos(last_pos), .bp_rdata(bp_rdata),
        .busy(busy), .done(done), .word_idx(word_idx), .pos_idx(pos_idx),
        .init_we(init_we), .max_en(max_en), .prob_we(prob_we), .bp_we(bp_we),
        .rw_last(rw_last), .bp_re(bp_re), .path_we(path_we),
        .path_addr(path_addr), .path_tag(path_tag)
    );

    always #5 clk = ~clk;

    // mode 0: argmax equals row; mode 1: argmax is the next row (mod 11)
    assign max_index = max_mode ? ((pos_idx == 4'd10) ? 4'd0 : pos_idx + 4'd1) : pos_idx;
    assign all_out = {busy, done, word_idx, pos_idx, init_we, max_en, prob_we, bp_we,
                      rw_last, bp_re, path_we, path_addr, path_tag};

    // Backpointer RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (bp_we) bp_mem[word_idx][pos_idx] <= max_index;
        if (bp_re) bp_rdata <= bp_mem[word_idx][pos_idx];
    end

    typedef struct {
        int         nw;
        logic [3:0] lp;
        bit         mode;
        int         exp_n;
        int         exp_lat;
        int         poke;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run(input vec_t v);
        int cyc = 0, init_cnt = 0, fwd_cnt = 0, rw_cnt = 0, bp_cnt = 0, path_cnt = 0;
        int path_err = 0, seq_err = 0, excl_err = 0, busy_err = 0, post_err = 0, ones;
        int exp_tag;
        bit got_done = 1'b0;
        max_mode  = v.mode;
        last_pos  = v.lp;
        num_words = 5'(v.nw);
        start     = 1'b1;
        while (!got_done && cyc < 400) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (v.poke != 0 && cyc == v.poke) begin
                start = 1'b1;
                num_words = 5'd1;
            end
            if (init_we) begin
                if (word_idx !== 4'd0 || int'(pos_idx) != init_cnt) seq_err++;
                init_cnt++;
            end
            if (bp_we) begin
                if (int'(word_idx) != 1 + fwd_cnt / 11 || int'(pos_idx) != fwd_cnt % 11) seq_err++;
                fwd_cnt++;
            end
            if (rw_last) begin
                if (int'(word_idx) != v.exp_n - 1) seq_err++;
                rw_cnt++;
            end
            if (bp_re) bp_cnt++;
            if (path_we) begin
                exp_tag = v.mode ? (int'(v.lp) + path_cnt) % 11 : int'(v.lp);
                if (int'(path_addr) != v.exp_n - 1 - path_cnt || int'(path_tag) != exp_tag) path_err++;
                path_cnt++;
            end
            ones = int'(init_we) + int'(rw_last) + int'(bp_re) + int'(path_we) + int'(bp_we) + int'(done);
            if (ones > 1 || max_en != (bp_we | rw_last) || prob_we != bp_we) excl_err++;
            if (done) begin
                got_done = 1'b1;
                if (busy) busy_err++;
            end else if (!busy) busy_err++;
        end
        chk("latency", got_done ? cyc : -1, v.exp_lat);
        chk("init_we_count", init_cnt, 11);
        chk("bp_we_count", fwd_cnt, 11 * (v.exp_n - 1));
        chk("rw_last_count", rw_cnt, 1);
        chk("bp_re_count", bp_cnt, v.exp_n - 1);
        chk("path_we_count", path_cnt, v.exp_n);
        chk("path_content", path_err, 0);
        chk("index_sequence", seq_err, 0);
        chk("strobe_exclusive", excl_err, 0);
        chk("busy_profile", busy_err, 0);
        // start presented during DONE must not launch a new run
        start = 1'b1;
        num_words = 5'(v.nw);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy || done) post_err++;
        end
        chk("start_in_done_ignored", post_err, 0);
    endtask

    vec_t vecs[5];

    initial begin
        int cnt;
        bit found;
        vecs[0] = '{nw: 1,  lp: 4'd7,  mode: 1'b0, exp_n: 1,  exp_lat: 14,  poke: 0};
        vecs[1] = '{nw: 3,  lp: 4'd5,  mode: 1'b0, exp_n: 3,  exp_lat: 40,  poke: 5};
        vecs[2] = '{nw: 16, lp: 4'd3,  mode: 1'b1, exp_n: 16, exp_lat: 209, poke: 0};
        vecs[3] = '{nw: 20, lp: 4'd9,  mode: 1'b0, exp_n: 16, exp_lat: 209, poke: 0};
        vecs[4] = '{nw: 2,  lp: 4'd10, mode: 1'b1, exp_n: 2,  exp_lat: 27,  poke: 30};
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) bp_mem[a][b] = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(all_out), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", int'(all_out), 0);

        for (int i = 0; i < 5; i++) run(vecs[i]);

        // zero-length sentence is rejected
        num_words = 5'd0;
        start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) cnt++;
        end
        chk("zero_len_ignored", cnt, 0);

        // abort in FWD at word 4
        num_words = 5'd8;
        max_mode = 1'b0;
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (bp_we && word_idx == 4'd4) found = 1'b1;
        end
        chk("abort_reached_word4", int'(found), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_outputs_zero", int'(all_out), 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy || done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        run('{nw: 3, lp: 4'd2, mode: 1'b0, exp_n: 3, exp_lat: 40, poke: 0});

        // reset asserted during traceback
        num_words = 5'd4;
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (bp_re) found = 1'b1;
        end
        chk("reset_reached_tb", int'(found), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_mid_tb_zero", int'(all_out), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_mid_tb_idle", int'(all_out), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
